sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
- Sequencing controller around a WIDTH-bit serial-in/parallel-out shift register.
- Frames a serial bit stream on a start pulse, qualifies each bit with b_valid, and counts WIDTH bits.
- Presents the assembled word on q with a valid/ready handshake to the downstream parallel consumer.
- Sits between the serial receive front end and the parallel datapath.

Parameters:
- WIDTH, 4, number of data bits per frame; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame-start pulse; sampled in every state.
- b  input  1  serial data bit.
- b_valid  input  1  b is meaningful this cycle.
- out_ready  input  1  downstream accepts q this cycle.
- q  output  WIDTH  assembled parallel word.
- q_valid  output  1  q holds a complete frame.
- busy  output  1  high in SHIFT (and PARITY) states.
- overrun  output  1  one-cycle pulse: b_valid arrived in HOLD and the bit was dropped.
- parity_err  output  1  parity mismatch flag for the word in HOLD; tied 0 without the optional feature.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-frame: state=IDLE; q=0; q_valid=0; busy=0; overrun=0; parity_err=0; counter=0.
- Shift rule: on each accepted bit, q <= {q[WIDTH-2:0], b}. The first bit received ends in q[WIDTH-1].
- IDLE:
  - start=1 -> SHIFT; counter cleared; q cleared.
  - b_valid alone is ignored.
- SHIFT:
  - Each cycle with b_valid=1 shifts one bit and increments the counter.
  - The edge that captures bit number WIDTH moves to HOLD; q_valid=1 from the next cycle.
  - Latency: q_valid is high exactly one cycle after the edge that captures the last data bit.
  - start=1 in SHIFT restarts the frame: counter=0, q=0, and any b_valid that cycle is discarded. Start takes priority over b.
- HOLD:
  - q and parity_err stay stable while q_valid=1.
  - Transfer occurs at an edge with q_valid=1 and out_ready=1; q_valid drops the next cycle.
  - After transfer, the next state is SHIFT if start=1 in the same cycle (q cleared), otherwise IDLE.
  - start without out_ready is ignored (no frame loss).
  - b_valid=1 in HOLD: the bit is dropped and overrun pulses for one cycle on the next cycle.
- q_valid never depends combinationally on out_ready. All outputs are registered.
- Counter saturates at WIDTH. It never wraps inside a frame.

Optional Feature:
- Macro: SIPO_FRAME_CTRL_PARITY_EN.
- With the macro:
  - After bit WIDTH, go to state PARITY instead of HOLD.
  - The next b_valid bit is the even-parity bit.
  - Then go to HOLD with parity_err = ^q ^ parity_bit; q_valid latency is measured from the parity-bit edge.
  - start in PARITY restarts the frame, as in SHIFT.
- Without the macro: no PARITY state; parity_err is constant 0.

Decomposition:
- Shared package sipo_ctrl_pkg:
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, HOLD=2'd3.
  - Default WIDTH constant.
- One sub-module, sipo_shift_core: WIDTH-bit shift register with clk, rst, clr, en, b, q. It holds no control logic.
- The FSM, counter, handshake and flags live in sipo_frame_ctrl.

Test Plan (WIDTH=4):
- Basic frame: start, then b=1,0,1,0 on consecutive b_valid cycles, out_ready=1 -> q=4'b1010, q_valid high one cycle after the 4th bit edge, back to IDLE.
- Gapped bits with backpressure: bits 1,1,0,1 with b_valid low between them, out_ready=0 for 5 cycles -> q=4'b1101 held stable, q_valid stays 1; transfer on the first ready cycle.
- Restart mid-frame: start, bits 1,1, start again, bits 0,0,1,1 -> q=4'b0011; the first partial frame is discarded.
- Overrun and back-to-back frames: in HOLD with out_ready=0, pulse b_valid -> overrun=1 for one cycle and q unchanged. Then out_ready=1 with start=1 in the same cycle -> directly to SHIFT and the next frame is received correctly.
- Reset mid-frame: rst=1 after 2 bits -> all outputs 0 next cycle. A following full frame 0,1,1,0 gives q=4'b0110.
- Parity (with macro): bits 1,0,1,1 plus parity bit 0 -> parity_err=1. With parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// rtl/sipo_ctrl_pkg.sv - shared state encoding and defaults for the SIPO frame controller
//
// Contents:
//   state_t       2-bit FSM state type
//   IDLE..HOLD    state encodings shared by RTL and any observer logic
//   DEFAULT_WIDTH default frame width in data bits
package sipo_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SHIFT  = 2'd1;
    localparam state_t PARITY = 2'd2;
    localparam state_t HOLD   = 2'd3;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// rtl/sipo_frame_ctrl_if.sv - serial-in / parallel-out handshake bundle for sipo_frame_ctrl
//
// Signals:
//   start       frame-start pulse          (master -> slave)
//   b, b_valid  serial bit and qualifier   (master -> slave)
//   out_ready   downstream accepts q       (master -> slave)
//   q, q_valid  assembled word and valid   (slave -> master)
//   busy        frame reception in progress (slave -> master)
//   overrun     bit dropped while holding  (slave -> master)
//   parity_err  parity mismatch of held word (slave -> master)
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             b;
    logic             b_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output start, b, b_valid, out_ready,
        input  q, q_valid, busy, overrun, parity_err
    );

    modport slave (
        input  start, b, b_valid, out_ready,
        output q, q_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - WIDTH-bit serial-in/parallel-out shift register, no control logic
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears q
//   clr  synchronous clear, takes priority over en
//   en   shift b into q[0]; earlier bits move toward q[WIDTH-1]
//   b    serial data bit
//   q    parallel contents
module sipo_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             b,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], b};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - frames a serial bit stream into WIDTH-bit words with valid/ready output
//
// Optional feature macro: SIPO_FRAME_CTRL_PARITY_EN (adds an even-parity bit after each frame)
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sipo_frame_ctrl_if.slave: start, b, b_valid, out_ready in;
//        q, q_valid, busy, overrun, parity_err out (all registered)
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_frame_ctrl_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             clr, en;
    logic [WIDTH-1:0] q_w;

    logic q_valid_r, busy_r, overrun_r, perr_r;
    logic q_valid_nxt, busy_nxt, overrun_nxt, perr_nxt;

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .b   (bus.b),
        .q   (q_w)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            q_valid_r <= q_valid_nxt;
            busy_r    <= busy_nxt;
            overrun_r <= overrun_nxt;
            perr_r    <= perr_nxt;
        end
    end

    // Next state plus shift-core controls. start outranks b in every
    // receiving state; in HOLD it only acts together with a transfer.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        en        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                    clr       = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    clr = 1'b1;
                end else if (bus.b_valid) begin
                    en = 1'b1;
                    if (cnt == CNT_LAST) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = HOLD;
`endif
                    end
                end
            end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            PARITY: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                    clr       = 1'b1;
                end else if (bus.b_valid) begin
                    state_nxt = HOLD;
                end
            end
`endif
            HOLD: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_nxt = SHIFT;
                        clr       = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of counter and registered outputs
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        q_valid_nxt = (state_nxt == HOLD);
        busy_nxt    = (state_nxt == SHIFT) || (state_nxt == PARITY);
        // Any bit offered while holding a word is lost; flag it once.
        overrun_nxt = (state == HOLD) && bus.b_valid;

        perr_nxt = perr_r;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        if (clr) begin
            perr_nxt = 1'b0;
        end else if ((state == PARITY) && bus.b_valid) begin
            perr_nxt = (^q_w) ^ bus.b;
        end
`else
        perr_nxt = 1'b0;
`endif
    end

    assign bus.q          = q_w;
    assign bus.q_valid    = q_valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    assign bus.parity_err = perr_r;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - scoreboard bench for sipo_frame_ctrl (WIDTH=4)
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // entry = {expected parity_err, expected q}
    logic [W:0] sb[$];
    logic [W:0] exp_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic v, input int gap);
        bus.b       = v;
        bus.b_valid = 1'b1;
        step();
        bus.b_valid = 1'b0;
        repeat (gap) step();
    endtask

    function automatic logic exp_perr(input logic [W-1:0] w, input logic pbit);
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        return (^w) ^ pbit;
`else
        return 1'b0;
`endif
    endfunction

    // Sends the data bits MSB-first (first bit lands in q[W-1]),
    // followed by the parity bit when that feature is built in.
    task automatic send_word(input logic [W-1:0] w, input int gap, input logic pbit);
        for (int i = W - 1; i >= 0; i--) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            send_bit(w[i], gap);
`else
            send_bit(w[i], (i == 0) ? 0 : gap);
`endif
        end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        send_bit(pbit, 0);
`endif
    endtask

    task automatic frame(input logic [W-1:0] w, input int gap, input logic pbit);
        sb.push_back({exp_perr(w, pbit), w});
        start_pulse();
        send_word(w, gap, pbit);
    endtask

    // Word consumer: a transfer happens on the coming edge
    always @(negedge clk) begin
        if (!rst && bus.q_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 32'(bus.q), 32'hFFFF_FFFF);
            end else begin
                exp_e = sb.pop_front();
                chk("q", 32'(bus.q), 32'(exp_e[W-1:0]));
                chk("parity_err", 32'(bus.parity_err), 32'(exp_e[W]));
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.b         = 1'b0;
        bus.b_valid   = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        step();
        step();
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_q_valid", 32'(bus.q_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_parity_err", 32'(bus.parity_err), 0);
        rst = 1'b0;
        step();

        // b_valid in IDLE is ignored
        send_bit(1'b1, 0);
        chk("idle_ignore_busy", 32'(bus.busy), 0);
        chk("idle_ignore_q", 32'(bus.q), 0);

        // Basic frame, consumer always ready
        bus.out_ready = 1'b1;
        sb.push_back({exp_perr(4'b1010, 1'b0), 4'b1010});
        start_pulse();
        chk("basic_busy", 32'(bus.busy), 1);
        send_word(4'b1010, 0, 1'b0);
        chk("basic_latency", 32'(bus.q_valid), 1);
        chk("basic_busy_hold", 32'(bus.busy), 0);
        step();
        chk("basic_drop", 32'(bus.q_valid), 0);
        chk("basic_idle", 32'(bus.busy), 0);

        // Gapped bits with backpressure
        bus.out_ready = 1'b0;
        frame(4'b1101, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_q_stable", 32'(bus.q), 32'h0000_000D);
            chk("bp_q_valid", 32'(bus.q_valid), 1);
            bus.start = (i == 2);   // start without ready must not lose the word
            step();
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_drop", 32'(bus.q_valid), 0);

        // Restart mid-frame discards the partial frame
        sb.push_back({exp_perr(4'b0011, 1'b0), 4'b0011});
        start_pulse();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        bus.start   = 1'b1;
        bus.b_valid = 1'b1;         // discarded: start wins
        bus.b       = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.b_valid = 1'b0;
        chk("restart_q_clr", 32'(bus.q), 0);
        send_word(4'b0011, 0, 1'b0);
        step();

        // Overrun in HOLD, then transfer with start straight into SHIFT
        bus.out_ready = 1'b0;
        frame(4'b1001, 0, 1'b0);
        send_bit(1'b0, 0);
        chk("overrun_pulse", 32'(bus.overrun), 1);
        chk("overrun_q", 32'(bus.q), 32'h0000_0009);
        step();
        chk("overrun_clear", 32'(bus.overrun), 0);
        sb.push_back({exp_perr(4'b0111, 1'b1), 4'b0111});
        bus.out_ready = 1'b1;
        start_pulse();
        chk("b2b_busy", 32'(bus.busy), 1);
        chk("b2b_q_clr", 32'(bus.q), 0);
        send_word(4'b0111, 0, 1'b1);
        step();

        // Reset mid-frame
        start_pulse();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_q", 32'(bus.q), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_q_valid", 32'(bus.q_valid), 0);
        frame(4'b0110, 0, 1'b0);
        step();

`ifdef SIPO_FRAME_CTRL_PARITY_EN
        bus.out_ready = 1'b0;
        frame(4'b1011, 0, 1'b0);
        chk("parity_bad", 32'(bus.parity_err), 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        frame(4'b1011, 0, 1'b1);
        chk("parity_good", 32'(bus.parity_err), 0);
        bus.out_ready = 1'b1;
        step();
`endif

        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("drain", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
